// File: rtl/audio_pkg.sv
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared audio constants and helpers for the capture/playback paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int PCM_W           = 8;
    localparam int FIFO_DEPTH_LOG2 = 4;

    // One PWM period spans every code of a width-bit sample.
    function automatic int pwm_period(input int width);
        return 1 << width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcm_pwm_player_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with level/full/empty; shared by record and play.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_wr_data,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_level == (DEPTH_LOG2+1)'(c_depth));
    assign o_empty = (r_level == '0);

    // A pop from an empty FIFO is refused, so a simultaneous push is never bypassed.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcm_pwm_player.sv
// ============================================================================
// Module   : pcm_pwm_player
// Purpose  : Buffers PCM samples and replays them as a 1-bit PWM audio stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcm_pwm_player
    import audio_pkg::*;
#(
    parameter int DATA_W     = PCM_W,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     pcm_data,
    input  logic                  pcm_valid,
    input  logic                  clr_flags,
    output logic                  pwm_out,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_period  = pwm_period(DATA_W);
    localparam logic [DATA_W-1:0] c_cnt_max = DATA_W'(c_period - 1);

    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_duty;
    logic              r_pwm;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push_req;
    logic              w_pop_cycle;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;
    logic              w_unf_set;

    assign w_push_req  = enable & pcm_valid;
    assign w_pop_cycle = enable & (r_cnt == c_cnt_max);

    // A full FIFO still accepts a sample in the pop cycle, so that is not a drop.
    assign w_ovf_set = w_push_req & w_full & ~w_pop_cycle;
    assign w_unf_set = w_pop_cycle & w_empty;

    sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push_req),
        .i_pop     (w_pop_cycle),
        .i_wr_data (pcm_data),
        .o_rd_data (w_rd_data),
        .o_level   (fifo_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_duty      <= '0;
            r_pwm       <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt <= enable ? r_cnt + 1'b1 : '0;
            if (w_pop_cycle && !w_empty) begin
                r_duty <= w_rd_data;
            end
            r_pwm <= enable && (r_cnt < r_duty);

            // Set has priority over a same-cycle clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign pwm_out    = r_pwm;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_pcm_pwm_player.sv
// ============================================================================
// Module   : tb_pcm_pwm_player
// Purpose  : Directed self-checking bench for pcm_pwm_player (period 16, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcm_pwm_player;

    localparam int DW = 4;
    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] pcm_data;
    logic          pcm_valid;
    logic          clr_flags;
    logic          pwm_out;
    logic [DL:0]   fifo_level;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;
    int ph       = 0;   // expected PWM counter value in the current cycle

    pcm_pwm_player #(
        .DATA_W     (DW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .clr_flags  (clr_flags),
        .pwm_out    (pwm_out),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ph = (reset || !enable) ? 0 : (ph + 1) % 16;
        #1;
    endtask

    task automatic wait_ph(input int p);
        int guard;
        guard = 0;
        while (ph != p && guard < 20) begin
            step();
            guard++;
        end
    endtask

    task automatic push(input int d);
        pcm_data  = d[DW-1:0];
        pcm_valid = 1'b1;
        step();
        pcm_valid = 1'b0;
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            step();
            h += int'(pwm_out);
        end
    endtask

    initial begin
        int h;
        int h2;
        int exp_d [5];
        exp_d = '{1, 2, 3, 4, 6};

        reset     = 1'b1;
        enable    = 1'b0;
        pcm_data  = '0;
        pcm_valid = 1'b0;
        clr_flags = 1'b0;
        step();
        step();
        chk("rst_pwm",   32'(pwm_out),    0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full",  32'(fifo_full),  0);
        chk("rst_ovf",   32'(overflow),   0);
        chk("rst_unf",   32'(underflow),  0);

        // Run with nothing buffered: silent output, underflow at first wrap.
        reset  = 1'b0;
        enable = 1'b1;
        count_high(15, h);
        chk("unf_before_wrap", 32'(underflow), 0);
        count_high(1, h2);
        chk("idle_highs",     32'(h + h2),     0);
        chk("unf_after_wrap", 32'(underflow),  1);
        chk("idle_empty",     32'(fifo_empty), 1);

        // Two samples, 4 then 12, then the last duty repeats.
        push(4);
        push(12);
        chk("level_two", 32'(fifo_level), 2);
        wait_ph(0);
        chk("level_after_pop", 32'(fifo_level), 1);
        count_high(16, h);
        chk("duty4_highs", 32'(h), 4);
        chk("level_drained", 32'(fifo_level), 0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        h = int'(pwm_out);
        chk("clr_unf", 32'(underflow), 0);
        count_high(15, h2);
        chk("duty12_highs", 32'(h + h2), 12);
        chk("unf_reset_again", 32'(underflow), 1);
        count_high(16, h);
        chk("duty12_repeat", 32'(h), 12);

        // Samples offered while disabled are ignored.
        enable    = 1'b0;
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_unf_idle", 32'(underflow), 0);
        push(9);
        chk("dis_push_level", 32'(fifo_level), 0);
        chk("dis_push_ovf",   32'(overflow),   0);

        // Five back-to-back pushes into a depth-4 FIFO drop the fifth.
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push(i);
        end
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_full",  32'(fifo_full),  1);
        chk("ovf_empty", 32'(fifo_empty), 0);
        chk("ovf_flag",  32'(overflow),   1);
        enable    = 1'b0;
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_ovf",         32'(overflow),   0);
        chk("dis_level_kept",  32'(fifo_level), 4);
        chk("dis_pwm_low",     32'(pwm_out),    0);

        // Push into a full FIFO during the pop cycle is accepted.
        enable = 1'b1;
        wait_ph(15);
        push(6);
        chk("full_pop_level", 32'(fifo_level), 4);
        chk("full_pop_full",  32'(fifo_full),  1);
        chk("full_pop_ovf",   32'(overflow),   0);
        chk("full_pop_unf",   32'(underflow),  0);
        for (int i = 0; i < 5; i++) begin
            count_high(16, h);
            chk($sformatf("play%0d_highs", i), 32'(h), 32'(exp_d[i]));
        end
        chk("play_empty", 32'(fifo_empty), 1);
        chk("play_unf",   32'(underflow),  1);

        // Reset mid-period with three samples buffered and output high.
        push(7);
        push(8);
        push(9);
        chk("pre_rst_pwm",   32'(pwm_out),    1);
        chk("pre_rst_level", 32'(fifo_level), 3);
        reset = 1'b1;
        step();
        chk("mid_rst_pwm",   32'(pwm_out),    0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_empty", 32'(fifo_empty), 1);
        chk("mid_rst_full",  32'(fifo_full),  0);
        chk("mid_rst_ovf",   32'(overflow),   0);
        chk("mid_rst_unf",   32'(underflow),  0);
        reset = 1'b0;
        count_high(16, h);
        chk("post_rst_highs", 32'(h), 0);
        chk("post_rst_unf",   32'(underflow), 1);

        // Duty extremes, then clear colliding with an underflow event.
        push(0);
        push(15);
        wait_ph(0);
        count_high(16, h);
        chk("duty_min_highs", 32'(h), 0);
        count_high(16, h);
        chk("duty_max_highs", 32'(h), 15);
        wait_ph(15);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_vs_set_unf", 32'(underflow), 1);
        chk("clr_vs_set_ovf", 32'(overflow),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
